// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM.
// slave = arbiter side, master = requesters plus RAM model side.
interface ram_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [WIDTH-1:0]      wdata0;
  logic [WIDTH-1:0]      wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [WIDTH-1:0]      rdata0;
  logic [WIDTH-1:0]      rdata1;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_din;
  logic                  ram_we;
  logic [WIDTH-1:0]      ram_dout;
  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output ack0, ack1, rdata0, rdata1, ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  ack0, ack1, rdata0, rdata1, ram_addr, ram_din, ram_we, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM; round-robin on ties by default,
// fixed priority to requester 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_gnt;
  logic                  w_gnt_nxt;
  logic                  r_last;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [WIDTH-1:0]      r_rdata0;
  logic [WIDTH-1:0]      r_rdata1;

  logic                  w_e0;
  logic                  w_e1;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [WIDTH-1:0]      w_ram_din;
  logic                  w_ram_we;

  // A requester is masked during its own ack cycle so a lingering req is not re-served.
  assign w_e0 = bus.req0 & ~r_ack0;
  assign w_e1 = bus.req1 & ~r_ack1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ram_addr  = '0;
    w_ram_din   = '0;
    w_ram_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_e0 && w_e1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          w_gnt_nxt = 1'b0;
`else
          w_gnt_nxt = ~r_last;
`endif
          w_state_nxt = S_ACCESS;
        end else if (w_e0) begin
          w_gnt_nxt   = 1'b0;
          w_state_nxt = S_ACCESS;
        end else if (w_e1) begin
          w_gnt_nxt   = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_IDLE;
        if (r_gnt) begin
          w_ram_addr = bus.addr1;
          w_ram_din  = bus.wdata1;
          w_ram_we   = bus.we1;
        end else begin
          w_ram_addr = bus.addr0;
          w_ram_din  = bus.wdata0;
          w_ram_we   = bus.we0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      // RAM read is combinational, so a write captures the pre-write word here.
      if (r_state == S_ACCESS) begin
        r_last <= r_gnt;
        if (r_gnt) begin
          r_ack1   <= 1'b1;
          r_rdata1 <= bus.ram_dout;
        end else begin
          r_ack0   <= 1'b1;
          r_rdata0 <= bus.ram_dout;
        end
      end
    end
  end

  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_din  = w_ram_din;
  assign bus.ram_we   = w_ram_we;
  assign bus.busy     = (r_state == S_ACCESS);
  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural async-read RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  ram_arbiter_if #(.WIDTH(16), .ADDR_WIDTH(8)) bus ();

  ram_arbiter #(.WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Unwritten locations read as {8'hC0, addr}, so pre-write contents are known.
  logic [15:0] mem [256];
  bit          written [256];

  assign bus.ram_dout = written[bus.ram_addr] ? mem[bus.ram_addr] : {8'hC0, bus.ram_addr};

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_din;
      written[bus.ram_addr] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ack1, ack0} for the 8 cycles of the contended sequence
`ifdef RAM_ARB_FIXED_PRIO_EN
  logic [1:0] tie_exp [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
  logic [1:0] tie_exp [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`endif
  logic [1:0] held_exp [6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    step();
    step();
    chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_we", bus.ram_we, 1'b0);
    chk("rst_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
    rst = 1'b0;
    step();

    // single write 16'hBEEF to addr 5 via port 0
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h05; bus.wdata0 = 16'hBEEF;
    chk("w_idle_busy", bus.busy, 1'b0);
    chk("w_idle_addr", bus.ram_addr, 8'h00);
    step();
    chk("w_acc_busy", bus.busy, 1'b1);
    chk("w_acc_we", bus.ram_we, 1'b1);
    chk("w_acc_addr", bus.ram_addr, 8'h05);
    chk("w_acc_din", bus.ram_din, 16'hBEEF);
    chk("w_acc_ack", bus.ack0, 1'b0);
    step();
    chk("w_ack0", bus.ack0, 1'b1);
    chk("w_rdata_old", bus.rdata0, 16'hC005);
    chk("w_ram_we_idle", bus.ram_we, 1'b0);
    bus.req0 = 1'b0;
    step();
    chk("w_ack0_pulse", bus.ack0, 1'b0);

    // read addr 5 via port 1
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h05;
    step();
    chk("r_acc_we", bus.ram_we, 1'b0);
    step();
    chk("r_ack1", bus.ack1, 1'b1);
    chk("r_rdata1", bus.rdata1, 16'hBEEF);
    bus.req1 = 1'b0;
    step();
    chk("r_ack1_pulse", bus.ack1, 1'b0);
    chk("r_rdata1_hold", bus.rdata1, 16'hBEEF);

    // read-during-write capture on addr 7
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h07; bus.wdata0 = 16'h1234;
    step();
    step();
    chk("rdw_ack_a", bus.ack0, 1'b1);
    bus.req0 = 1'b0;
    step();
    bus.req0 = 1'b1; bus.wdata0 = 16'h5678;
    step();
    step();
    chk("rdw_ack_b", bus.ack0, 1'b1);
    chk("rdw_rdata", bus.rdata0, 16'h1234);
    bus.req0 = 1'b0;
    step();

    // both held for 4 accesses; last served was port 0
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h07;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h05;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("tie_acks_c%0d", i + 1), {bus.ack1, bus.ack0}, tie_exp[i]);
      if (i == 7) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    chk("tie_rdata0", bus.rdata0, 16'h5678);
    chk("tie_rdata1", bus.rdata1, 16'hBEEF);
    step();
    chk("tie_done_busy", bus.busy, 1'b0);
    chk("tie_done_ack", {bus.ack1, bus.ack0}, 2'b00);

    // req1 held two cycles past its ack: exactly one extra access
    bus.req1 = 1'b1; bus.addr1 = 8'h05;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("held_acks_c%0d", i + 2), {bus.ack1, bus.ack0}, held_exp[i]);
      if (i == 3) bus.req1 = 1'b0;
    end

    // reset asserted mid-ACCESS of a write of 16'hAAAA to addr 3
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h03; bus.wdata0 = 16'hAAAA;
    step();
    chk("ra_we_before", bus.ram_we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ra_we_drop", bus.ram_we, 1'b0);
    chk("ra_busy_drop", bus.busy, 1'b0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("ra_no_write", {31'd0, written[3]}, 32'd0);
    chk("ra_no_ack", bus.ack0, 1'b0);
    rst = 1'b0;
    step();
    chk("ra_post_ack", {bus.ack1, bus.ack0}, 2'b00);
    chk("ra_post_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
    chk("ra_post_busy", bus.busy, 1'b0);
    chk("ra_post_addr", bus.ram_addr, 8'h00);
    bus.we0 = 1'b0;
    bus.req0 = 1'b1;
    step();
    step();
    chk("ra_read_ack", bus.ack0, 1'b1);
    chk("ra_read_old", bus.rdata0, 16'hC003);
    bus.req0 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
